instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped instruction cache serving fetch-stage instruction reads, replacing the flat instruction memory. Returns a 32-bit instruction in the same cycle as the PC on a hit. On a miss it stalls fetch, refills one line from the lower memory over a valid-handshake burst, then resumes. Sits between the fetch PC register and the memory-side bus.

## Interface
Parameters:
- ADDR_WIDTH, 64, fetch/memory address width
- INSTR_WIDTH, 32, instruction and memory beat width
- BLOCK_WORDS, 4, instructions per line (power of 2, ≥2)
- SET_COUNT, 16, number of lines (power of 2, ≥2)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, rising edge
- i_arst  in  1  asynchronous reset, active-low
- i_req  in  1  fetch request valid
- i_addr  in  ADDR_WIDTH  fetch PC (bits [1:0] ignored)
- i_invalidate  in  1  clear all valid bits (fence.i)
- o_instruction  out  INSTR_WIDTH  instruction for i_addr; valid when o_hit
- o_hit  out  1  i_req hit this cycle
- o_stall_fetch  out  1  hold PC and fetch pipeline register
- o_mem_req  out  1  refill burst request
- o_mem_addr  out  ADDR_WIDTH  line-aligned refill address
- i_mem_valid  in  1  refill beat valid
- i_mem_data  in  INSTR_WIDTH  refill beat, ascending word order from offset 0

## Operation
- Address split: word offset = log2(BLOCK_WORDS) bits above [1:0]; index = log2(SET_COUNT) bits above that; tag = remaining upper bits (defaults: offset [3:2], index [7:4], tag [63:8]).
- Hit = i_req & state IDLE & valid[index] & tag match; combinational, no registered output.
- FSM states: IDLE, REFILL.
  - IDLE: i_req & miss → capture line address, go REFILL. i_req low → no action.
  - REFILL: o_mem_req=1, o_mem_addr = captured line address (stable). Each i_mem_valid writes i_mem_data at word counter, counter++. Beat at counter = BLOCK_WORDS-1 writes tag, sets valid (unless dropped), counter→0, go IDLE.
- o_stall_fetch = (state==REFILL) | (i_req & ~hit in IDLE).
- i_mem_valid in IDLE ignored.
- i_req falling or i_addr changing during REFILL: refill completes with captured address; line filled valid.
- i_invalidate in IDLE: all valid bits cleared next edge; hit same cycle still uses old valid bits.
- i_invalidate in REFILL: all valid bits cleared, drop flag set; completing line not marked valid; drop flag cleared on return to IDLE.
- Reset (any state, incl. mid-refill): state IDLE, counter 0, all valid 0, drop flag 0. Outputs at reset: o_mem_req 0, o_mem_addr 0, o_hit 0, o_stall_fetch = i_req (miss), o_instruction 0 when not hit. Data/tag arrays not reset.

## Timing
- Hit latency 0 cycles (combinational from i_addr).
- Miss at cycle N: stall at N; REFILL from N+1; with i_mem_valid every cycle, beats at N+1..N+BLOCK_WORDS; IDLE and hit at N+BLOCK_WORDS+1 (default: stall N..N+4, hit N+5).
- Memory wait states extend REFILL one cycle per idle cycle; no timeout.
- o_mem_req deasserts the edge after the last beat.

## Configuration
- ICACHE_PERF_CNT_EN defined: adds outputs o_hit_count, o_miss_count (32 bits each, reset 0, saturate at all-ones). Hit counts per cycle o_hit=1; miss counts once per IDLE→REFILL transition.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package cache_pkg: FSM state enum (IDLE, REFILL), localparams for offset/index/tag widths derived from parameters.
- One sub-module: instr_cache_data_array (SET_COUNT×BLOCK_WORDS words, one write port, one combinational read port). Tag/valid arrays and FSM in top.

## Test plan
- Reset, i_req=1, i_addr=0x100 → o_stall_fetch=1, o_mem_req=1 next cycle, o_mem_addr=0x100.
- Feed 4 beats 0xA0..0xA3 back-to-back → stall low 5 cycles after miss; i_addr=0x108 hits with 0xA2 at 0 latency.
- Refill with one idle cycle between beats 1 and 2 → completes one cycle later; all words correct.
- i_invalidate during refill of 0x200 → after completion, 0x200 misses again; 0x100 misses too.
- Conflict: 0x100 filled, then 0x1100 (same index, different tag) → miss, refill evicts; 0x100 then misses.
- Reset asserted mid-refill (after beat 2) → o_mem_req 0 immediately, state IDLE; re-request misses and refills fully.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the instruction cache.
package cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } cache_state_e;

    // Instruction fetch is word aligned, so the two byte bits are never used.
    localparam int unsigned BYTE_OFFSET_W = 2;

    // Bits that select a word inside a line.
    function automatic int unsigned offset_width(input int unsigned block_words);
        return $clog2(block_words);
    endfunction

    // Bits that select a line (set).
    function automatic int unsigned index_width(input int unsigned set_count);
        return $clog2(set_count);
    endfunction

    // Bits that remain above the index and form the tag.
    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned block_words,
                                              input int unsigned set_count);
        return addr_width - BYTE_OFFSET_W - $clog2(block_words) - $clog2(set_count);
    endfunction

    // Widths for the default geometry (64-bit address, 4 words, 16 sets).
    localparam int unsigned DEF_OFFSET_W = 2;
    localparam int unsigned DEF_INDEX_W  = 4;
    localparam int unsigned DEF_TAG_W    = 56;

endpackage

// File: rtl/instr_cache_data_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
module instr_cache_data_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Refill beat write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle read for zero-latency hits.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with single-line burst refill.
// Optional feature: define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module instr_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned SET_COUNT   = 16
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic                   i_invalidate,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic                   o_hit,
    output logic                   o_stall_fetch,
    output logic                   o_mem_req,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]            o_hit_count,
    output logic [31:0]            o_miss_count,
`endif
    input  logic                   i_mem_valid,
    input  logic [INSTR_WIDTH-1:0] i_mem_data
);

    localparam int unsigned OFFSET_W = offset_width(BLOCK_WORDS);
    localparam int unsigned INDEX_W  = index_width(SET_COUNT);
    localparam int unsigned TAG_W    = tag_width(ADDR_WIDTH, BLOCK_WORDS, SET_COUNT);
    localparam int unsigned LINE_LSB = BYTE_OFFSET_W + OFFSET_W;
    localparam int unsigned TAG_LSB  = LINE_LSB + INDEX_W;
    localparam int unsigned LINE_W   = ADDR_WIDTH - LINE_LSB;
    localparam int unsigned ARR_AW   = INDEX_W + OFFSET_W;
    localparam int unsigned ARR_D    = SET_COUNT * BLOCK_WORDS;

    cache_state_e            state_q;
    logic [OFFSET_W-1:0]     beat_cnt_q;
    logic [LINE_W-1:0]       line_q;
    logic                    drop_q;
    logic                    mem_req_q;
    logic [SET_COUNT-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_mem [SET_COUNT];

    logic [INDEX_W-1:0]      req_index;
    logic [OFFSET_W-1:0]     req_offset;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      fill_index;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;
    logic                    beat_we;
    logic                    last_beat;
    logic [INSTR_WIDTH-1:0]  rd_data;
    logic                    unused_addr_lsb;

    assign req_index       = i_addr[LINE_LSB +: INDEX_W];
    assign req_offset      = i_addr[BYTE_OFFSET_W +: OFFSET_W];
    assign req_tag         = i_addr[TAG_LSB +: TAG_W];
    assign fill_index      = line_q[INDEX_W-1:0];
    assign fill_tag        = line_q[INDEX_W +: TAG_W];
    assign unused_addr_lsb = ^i_addr[BYTE_OFFSET_W-1:0];

    // Lookup and refill beat decode.
    always_comb begin
        hit       = i_req && (state_q == IDLE) && valid_q[req_index]
                    && (tag_mem[req_index] == req_tag);
        beat_we   = (state_q == REFILL) && i_mem_valid;
        last_beat = beat_we && (beat_cnt_q == OFFSET_W'(BLOCK_WORDS - 1));
    end

    assign o_hit         = hit;
    assign o_instruction = hit ? rd_data : '0;
    assign o_stall_fetch = (state_q == REFILL) || (i_req && !hit);
    assign o_mem_req     = mem_req_q;
    assign o_mem_addr    = {line_q, {LINE_LSB{1'b0}}};

    instr_cache_data_array #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (ARR_D),
        .AW    (ARR_AW)
    ) u_data (
        .clk   (i_clk),
        .we    (beat_we),
        .waddr ({fill_index, beat_cnt_q}),
        .wdata (i_mem_data),
        .raddr ({req_index, req_offset}),
        .rdata (rd_data)
    );

    // Miss detection, refill sequencing and memory request.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            line_q     <= '0;
            drop_q     <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req && !hit) begin
                        state_q   <= REFILL;
                        line_q    <= i_addr[ADDR_WIDTH-1:LINE_LSB];
                        mem_req_q <= 1'b1;
                    end
                end
                REFILL: begin
                    if (i_invalidate) begin
                        drop_q <= 1'b1;
                    end
                    if (i_mem_valid) begin
                        beat_cnt_q <= beat_cnt_q + OFFSET_W'(1);
                        if (last_beat) begin
                            state_q    <= IDLE;
                            mem_req_q  <= 1'b0;
                            beat_cnt_q <= '0;
                            drop_q     <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Valid bits: invalidate wins over a completing fill; dropped fills stay invalid.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            valid_q <= '0;
        end else if (i_invalidate) begin
            valid_q <= '0;
        end else if (last_beat && !drop_q) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // Tag write on the final beat of a refill.
    always_ff @(posedge i_clk) begin
        if (last_beat) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Saturating hit/miss event counters.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            if (hit && (o_hit_count != '1)) begin
                o_hit_count <= o_hit_count + 32'(1);
            end
            if ((state_q == IDLE) && i_req && !hit && (o_miss_count != '1)) begin
                o_miss_count <= o_miss_count + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache against a line-level reference model.
module tb_instr_cache;

    logic        i_clk;
    logic        i_arst;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_invalidate;
    logic [31:0] o_instruction;
    logic        o_hit;
    logic        o_stall_fetch;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] o_hit_count;
    logic [31:0] o_miss_count;
`endif

    int checks;
    int failures;

    // Reference model: one entry per set, data stored per word.
    bit              m_valid [16];
    longint unsigned m_tag   [16];
    logic [31:0]     m_data  [16][4];
    logic [31:0]     beats   [4];

    instr_cache dut (
        .i_clk         (i_clk),
        .i_arst        (i_arst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_invalidate  (i_invalidate),
        .o_instruction (o_instruction),
        .o_hit         (o_hit),
        .o_stall_fetch (o_stall_fetch),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
`ifdef ICACHE_PERF_CNT_EN
        .o_hit_count   (o_hit_count),
        .o_miss_count  (o_miss_count),
`endif
        .i_mem_valid   (i_mem_valid),
        .i_mem_data    (i_mem_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int m_idx(input longint unsigned a);
        return int'((a / 16) % 16);
    endfunction

    function automatic int m_off(input longint unsigned a);
        return int'((a / 4) % 4);
    endfunction

    function automatic longint unsigned m_tg(input longint unsigned a);
        return a / 256;
    endfunction

    function automatic bit m_hit(input longint unsigned a);
        return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == m_tg(a));
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
    endtask

    task automatic m_fill(input longint unsigned a, input bit dropped);
        if (dropped) m_clear();
        m_tag[m_idx(a)]   = m_tg(a);
        m_valid[m_idx(a)] = !dropped;
        for (int w = 0; w < 4; w++) m_data[m_idx(a)][w] = beats[w];
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one line of beats from 'beats', optional idle gap and invalidate pulse.
    task automatic serve_refill(input int gap_at, input int gap_len, input int inval_at,
                                output bit dropped);
        dropped = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (w == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    i_mem_valid = 1'b0;
                    tick();
                end
            end
            i_mem_valid = 1'b1;
            i_mem_data  = beats[w];
            if (w == inval_at) begin
                i_invalidate = 1'b1;
                dropped      = 1'b1;
            end
            tick();
            i_invalidate = 1'b0;
        end
        i_mem_valid = 1'b0;
        i_mem_data  = '0;
    endtask

    task automatic test_reset();
        i_arst = 1'b0;
        tick();
        tick();
        checks++;
        if (o_stall_fetch !== 1'b0 || o_mem_req !== 1'b0 || o_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle stall=%b mem_req=%b hit=%b required 0/0/0",
                     o_stall_fetch, o_mem_req, o_hit);
        end
        i_req  = 1'b1;
        i_addr = 64'h100;
        #1;
        checks++;
        if (o_stall_fetch !== 1'b1 || o_hit !== 1'b0 || o_mem_addr !== 64'h0
            || o_instruction !== 32'h0) begin
            failures++;
            $display("FAIL reset_req stall=%b hit=%b mem_addr=%h instr=%h required 1/0/0/0",
                     o_stall_fetch, o_hit, o_mem_addr, o_instruction);
        end
        i_req = 1'b0;
        tick();
        i_arst = 1'b1;
        m_clear();
        tick();
    endtask

    task automatic test_miss_refill();
        i_req  = 1'b1;
        i_addr = 64'h100;
        #1;
        checks++;
        if (o_stall_fetch !== 1'b1 || o_hit !== 1'b0 || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL miss_cycle stall=%b hit=%b mem_req=%b required 1/0/0",
                     o_stall_fetch, o_hit, o_mem_req);
        end
        tick();
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h100) begin
            failures++;
            $display("FAIL refill_req mem_req=%b mem_addr=%h required 1/0000000000000100",
                     o_mem_req, o_mem_addr);
        end
        for (int w = 0; w < 4; w++) begin
            beats[w]    = 32'hA0 + 32'(w);
            i_mem_valid = 1'b1;
            i_mem_data  = beats[w];
            #1;
            checks++;
            if (o_stall_fetch !== 1'b1 || o_hit !== 1'b0) begin
                failures++;
                $display("FAIL refill_stall beat=%0d stall=%b hit=%b required 1/0",
                         w, o_stall_fetch, o_hit);
            end
            tick();
        end
        i_mem_valid = 1'b0;
        m_fill(64'h100, 1'b0);
        #1;
        checks++;
        if (o_hit !== 1'b1 || o_stall_fetch !== 1'b0 || o_instruction !== 32'hA0
            || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL first_hit hit=%b stall=%b instr=%h mem_req=%b required 1/0/a0/0",
                     o_hit, o_stall_fetch, o_instruction, o_mem_req);
        end
        i_addr = 64'h108;
        #1;
        checks++;
        if (o_hit !== 1'b1 || o_instruction !== 32'hA2) begin
            failures++;
            $display("FAIL hit_0x108 hit=%b instr=%h required 1/a2", o_hit, o_instruction);
        end
        tick();
    endtask

    task automatic test_wait_state();
        bit dropped;
        i_req  = 1'b1;
        i_addr = 64'h340;
        tick();
        for (int w = 0; w < 4; w++) beats[w] = 32'hB0 + 32'(w);
        serve_refill(2, 1, -1, dropped);
        m_fill(64'h340, dropped);
        for (int w = 0; w < 4; w++) begin
            i_addr = 64'h340 + 64'(4 * w);
            #1;
            checks++;
            if (o_hit !== 1'b1 || o_instruction !== m_data[4][w]) begin
                failures++;
                $display("FAIL wait_state_word%0d hit=%b instr=%h required 1/%h",
                         w, o_hit, o_instruction, m_data[4][w]);
            end
        end
        tick();
    endtask

    task automatic test_invalidate_refill();
        bit dropped;
        i_req  = 1'b1;
        i_addr = 64'h200;
        tick();
        i_invalidate = 1'b1;
        i_mem_valid  = 1'b0;
        tick();
        i_invalidate = 1'b0;
        for (int w = 0; w < 4; w++) beats[w] = 32'hC0 + 32'(w);
        serve_refill(-1, 0, -1, dropped);
        m_fill(64'h200, 1'b1);
        #1;
        checks++;
        if (o_hit !== 1'b0 || o_stall_fetch !== 1'b1) begin
            failures++;
            $display("FAIL inval_0x200 hit=%b stall=%b required 0/1", o_hit, o_stall_fetch);
        end
        i_addr = 64'h100;
        #1;
        checks++;
        if (o_hit !== 1'b0 || o_stall_fetch !== 1'b1) begin
            failures++;
            $display("FAIL inval_0x100 hit=%b stall=%b required 0/1", o_hit, o_stall_fetch);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        bit dropped;
        i_req  = 1'b1;
        i_addr = 64'h100;
        tick();
        for (int w = 0; w < 4; w++) beats[w] = 32'hD0 + 32'(w);
        serve_refill(-1, 0, -1, dropped);
        m_fill(64'h100, dropped);
        i_addr = 64'h1100;
        #1;
        checks++;
        if (o_hit !== 1'b0 || o_stall_fetch !== 1'b1) begin
            failures++;
            $display("FAIL conflict_miss hit=%b stall=%b required 0/1", o_hit, o_stall_fetch);
        end
        tick();
        checks++;
        if (o_mem_addr !== 64'h1100) begin
            failures++;
            $display("FAIL conflict_addr mem_addr=%h required 0000000000001100", o_mem_addr);
        end
        for (int w = 0; w < 4; w++) beats[w] = 32'hE0 + 32'(w);
        serve_refill(-1, 0, -1, dropped);
        m_fill(64'h1100, dropped);
        i_addr = 64'h110C;
        #1;
        checks++;
        if (o_hit !== 1'b1 || o_instruction !== 32'hE3) begin
            failures++;
            $display("FAIL conflict_hit hit=%b instr=%h required 1/e3", o_hit, o_instruction);
        end
        i_addr = 64'h100;
        #1;
        checks++;
        if (o_hit !== 1'b0 || o_stall_fetch !== 1'b1) begin
            failures++;
            $display("FAIL evicted_0x100 hit=%b stall=%b required 0/1", o_hit, o_stall_fetch);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_refill();
        bit dropped;
        i_req  = 1'b1;
        i_addr = 64'h400;
        tick();
        for (int w = 0; w < 2; w++) begin
            i_mem_valid = 1'b1;
            i_mem_data  = 32'hF0 + 32'(w);
            tick();
        end
        i_mem_valid = 1'b0;
        #2;
        i_arst = 1'b0;
        #1;
        checks++;
        if (o_mem_req !== 1'b0 || o_mem_addr !== 64'h0 || o_hit !== 1'b0
            || o_stall_fetch !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid mem_req=%b mem_addr=%h hit=%b stall=%b required 0/0/0/1",
                     o_mem_req, o_mem_addr, o_hit, o_stall_fetch);
        end
        m_clear();
        tick();
        i_arst = 1'b1;
        #1;
        checks++;
        if (o_hit !== 1'b0 || o_stall_fetch !== 1'b1) begin
            failures++;
            $display("FAIL rereq_miss hit=%b stall=%b required 0/1", o_hit, o_stall_fetch);
        end
        tick();
        checks++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== 64'h400) begin
            failures++;
            $display("FAIL rereq_addr mem_req=%b mem_addr=%h required 1/0000000000000400",
                     o_mem_req, o_mem_addr);
        end
        for (int w = 0; w < 4; w++) beats[w] = 32'h1F0 + 32'(w);
        serve_refill(-1, 0, -1, dropped);
        m_fill(64'h400, dropped);
        for (int w = 0; w < 4; w++) begin
            i_addr = 64'h400 + 64'(4 * w);
            #1;
            checks++;
            if (o_hit !== 1'b1 || o_instruction !== m_data[0][w]) begin
                failures++;
                $display("FAIL rereq_word%0d hit=%b instr=%h required 1/%h",
                         w, o_hit, o_instruction, m_data[0][w]);
            end
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        longint unsigned a;
        bit exp_hit;
        bit dropped;
        int inval_at;
        for (int it = 0; it < 80; it++) begin
            a = longint'($urandom_range(3, 0)) * 256 + longint'($urandom_range(15, 0)) * 16
                + longint'($urandom_range(3, 0)) * 4 + longint'($urandom_range(3, 0));
            i_req  = 1'b1;
            i_addr = a;
            #1;
            exp_hit = m_hit(a);
            checks++;
            if (o_hit !== exp_hit || o_stall_fetch !== !exp_hit || o_mem_req !== 1'b0
                || (exp_hit && o_instruction !== m_data[m_idx(a)][m_off(a)])) begin
                failures++;
                $display("FAIL rand_lookup addr=%h hit=%b stall=%b instr=%h required %b/%b/%h",
                         a, o_hit, o_stall_fetch, o_instruction, exp_hit, !exp_hit,
                         m_data[m_idx(a)][m_off(a)]);
            end
            if (!exp_hit) begin
                tick();
                checks++;
                if (o_mem_req !== 1'b1 || o_mem_addr !== (a & ~64'hF)) begin
                    failures++;
                    $display("FAIL rand_refill_addr mem_req=%b mem_addr=%h required 1/%h",
                             o_mem_req, o_mem_addr, a & ~64'hF);
                end
                for (int w = 0; w < 4; w++) beats[w] = $urandom();
                inval_at = ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
                serve_refill(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                             inval_at, dropped);
                m_fill(a, dropped);
                #1;
                checks++;
                if (o_hit !== !dropped || o_mem_req !== 1'b0
                    || (!dropped && o_instruction !== m_data[m_idx(a)][m_off(a)])) begin
                    failures++;
                    $display("FAIL rand_after_fill addr=%h hit=%b instr=%h required %b/%h",
                             a, o_hit, o_instruction, !dropped, m_data[m_idx(a)][m_off(a)]);
                end
                if (dropped) i_req = 1'b0;
            end
            tick();
            if ($urandom_range(9, 0) == 0) begin
                i_req        = 1'b0;
                i_invalidate = 1'b1;
                tick();
                i_invalidate = 1'b0;
                m_clear();
            end
        end
        i_req = 1'b0;
        tick();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        i_arst       = 1'b0;
        i_req        = 1'b0;
        i_addr       = '0;
        i_invalidate = 1'b0;
        i_mem_valid  = 1'b0;
        i_mem_data   = '0;
        test_reset();
        test_miss_refill();
        test_wait_state();
        test_invalidate_refill();
        test_conflict();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
